circ_queue_reader: RTL

- Consumer-side controller for the 16-entry, 8-bit circular queue.
- Mirrors producer write strobes to track occupancy and owns the read pointer.
- Drives the queue's read index and absorbs its 1-cycle synchronous read latency.
- Presents entries in FIFO order on a valid/ready stream, with full, empty and overflow status back to the producer.

---
 rtl/circ_queue_reader_pkg.sv | 20 ++
 rtl/circ_queue_reader_skid_buf2.sv | 87 ++++++++
 rtl/circ_queue_reader.sv | 94 +++++++++
 3 files changed

// File: rtl/circ_queue_reader_pkg.sv
// Shared constants for the 16-entry circular queue and its reader.
package queue_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  // Occupancy of the two-slot output skid buffer
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // Read pointer advance; wraps naturally because DEPTH is a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/circ_queue_reader_skid_buf2.sv
// Two-entry valid/ready skid buffer. Head slot drives the stream output;
// the tail slot absorbs one extra entry while the consumer stalls.
module skid_buf2
  import queue_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic [1:0]   occupancy_o
);

  skid_state_e state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop_eff;

  assign pop_eff = pop_i && (state_q != SKID_EMPTY);

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SKID_EMPTY;
    else     state_q <= state_d;
  end

  // Occupancy next state from push/pop
  always_comb begin
    state_d = state_q;
    case (state_q)
      SKID_EMPTY: if (push_i) state_d = SKID_ONE;
      SKID_ONE: begin
        if (push_i && !pop_eff)      state_d = SKID_TWO;
        else if (!push_i && pop_eff) state_d = SKID_EMPTY;
      end
      SKID_TWO: if (pop_eff && !push_i) state_d = SKID_ONE;
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Stream outputs derived from occupancy
  always_comb begin
    valid_o     = (state_q != SKID_EMPTY);
    occupancy_o = 2'(state_q);
    data_o      = head_q;
  end

  // Slot updates: a pop shifts tail into head, a push fills the first free slot
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      SKID_EMPTY: if (push_i) head_d = push_data_i;
      SKID_ONE: begin
        if (push_i && pop_eff) head_d = push_data_i;
        else if (push_i)       tail_d = push_data_i;
      end
      SKID_TWO: begin
        if (pop_eff) begin
          head_d = tail_q;
          if (push_i) tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Slot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Upstream credit logic must never push into a full buffer without a pop
  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_eff && state_q == SKID_TWO));

endmodule

// File: rtl/circ_queue_reader.sv
// Consumer-side controller for the circular queue: tracks occupancy from the
// producer's write strobes, owns the read pointer, absorbs the queue's
// one-cycle read latency and presents entries on a valid/ready stream.
module circ_queue_reader #(
  parameter int unsigned DATA_W = queue_pkg::DATA_W,
  parameter int unsigned DEPTH  = queue_pkg::DEPTH,
  parameter int unsigned PTR_W  = queue_pkg::PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              write,
  output logic [PTR_W-1:0]  read,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             overflow_q, overflow_d;

  logic       pop;
  logic       issue;
  logic       wr_acc;
  logic [1:0] skid_occ;
  logic [2:0] pending;

  assign pop   = dout_valid && dout_ready;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Held plus in-flight entries after this cycle's pop must leave room for
  // one more in the skid buffer, so an issue can never be dropped.
  assign pending = 3'(skid_occ) + 3'(inflight_q) - 3'(pop);
  assign issue   = en && !empty && (pending < 3'd2);
  // A write at full is still taken when an issue frees a slot this cycle
  assign wr_acc  = en && write && (!full || issue);

  // Next-state for pointer, occupancy count, in-flight flag and overflow
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = issue;
    overflow_d = overflow_q;
    if (issue) rd_ptr_d = queue_pkg::ptr_inc(rd_ptr_q);
    case ({wr_acc, issue})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    if (en && write && full && !issue) overflow_d = 1'b1;
  end

  // Controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  assign read     = rd_ptr_q;
  assign count    = count_q;
  assign overflow = overflow_q;

  // Queue data registered one edge after issue is captured into the skid buffer
  skid_buf2 #(
    .W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (rd_data),
    .pop_i       (dout_ready),
    .data_o      (dout),
    .valid_o     (dout_valid),
    .occupancy_o (skid_occ)
  );

endmodule
